// File: rtl/fpu_f32_div_seq.sv
// Multi-cycle IEEE-754 single-precision divider: radix-2 restoring mantissa
// iteration, round-to-nearest-even, flush-to-zero on both inputs and outputs.
module fpu_f32_div_seq #(
    parameter int STEPS_PER_CYCLE = 1,
    parameter int TAG_W           = 4
) (
    input  logic             MCLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      A,
    input  logic [31:0]      B,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [31:0]      O,
    output logic [4:0]       FLAGS,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic             BUSY
);
    localparam int N = 27 / STEPS_PER_CYCLE;

    generate
        if (STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 3 &&
            STEPS_PER_CYCLE != 9 && STEPS_PER_CYCLE != 27) begin : g_bad_steps
            $error("fpu_f32_div_seq: STEPS_PER_CYCLE must be 1, 3, 9 or 27");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_ROUND, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              sign_q, sign_d;
    logic signed [9:0] exp_q, exp_d;
    logic [23:0]       div_q, div_d;
    logic [24:0]       rem_q, rem_d;
    logic [26:0]       quo_q, quo_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [31:0]       o_q, o_d;
    logic [4:0]        flags_q, flags_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic              in_ready_q, out_valid_q, busy_q;

    // Operand classification; exponent 0 covers denormals (flushed to zero).
    logic [7:0]        ea, eb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special;
    logic              sign_in;
    logic signed [9:0] exp_in;
    logic [31:0]       spec_o;
    logic [4:0]        spec_flags;

    assign ea      = A[30:23];
    assign eb      = B[30:23];
    assign a_zero  = (ea == 8'd0);
    assign b_zero  = (eb == 8'd0);
    assign a_inf   = (ea == 8'hFF) && (A[22:0] == 23'd0);
    assign b_inf   = (eb == 8'hFF) && (B[22:0] == 23'd0);
    assign a_nan   = (ea == 8'hFF) && (A[22:0] != 23'd0);
    assign b_nan   = (eb == 8'hFF) && (B[22:0] != 23'd0);
    assign special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
    assign sign_in = A[31] ^ B[31];
    assign exp_in  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;

    always_comb begin
        spec_o     = {sign_in, 31'd0};
        spec_flags = 5'b00000;
        if (a_nan || b_nan) begin
            spec_o = 32'h7FC00000;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_o     = 32'h7FC00000;
            spec_flags = 5'b10000;
        end else if (a_inf) begin
            spec_o = {sign_in, 8'hFF, 23'd0};
        end else if (b_zero) begin
            spec_o     = {sign_in, 8'hFF, 23'd0};
            spec_flags = 5'b01000;
        end
    end

    // Restoring step chain: STEPS_PER_CYCLE quotient bits per clock.
    logic [24:0] rem_chain [0:STEPS_PER_CYCLE];
    logic [26:0] quo_chain [0:STEPS_PER_CYCLE];
    assign rem_chain[0] = rem_q;
    assign quo_chain[0] = quo_q;

    genvar gi;
    generate
        for (gi = 0; gi < STEPS_PER_CYCLE; gi++) begin : g_step
            logic [25:0] diff;
            logic [24:0] rem_sel;
            assign diff    = {1'b0, rem_chain[gi]} - {2'b00, div_q};
            assign rem_sel = diff[25] ? rem_chain[gi] : diff[24:0];
            assign rem_chain[gi+1] = rem_sel << 1;
            assign quo_chain[gi+1] = (quo_chain[gi] << 1) | {26'd0, ~diff[25]};
        end
    endgenerate

    // Normalise, then round to nearest even on {mant, guard, sticky}.
    logic [26:0]       quo_norm;
    logic signed [9:0] exp_norm, exp_fin;
    logic [23:0]       mant;
    logic              guard, sticky, round_up;
    logic [24:0]       mant_rnd;
    logic [22:0]       frac_fin;

    assign quo_norm = quo_q[26] ? quo_q : (quo_q << 1);
    assign exp_norm = quo_q[26] ? exp_q : exp_q - 10'sd1;
    assign mant     = quo_norm[26:3];
    assign guard    = quo_norm[2];
    assign sticky   = (|quo_norm[1:0]) | (|rem_q);
    assign round_up = guard & (sticky | mant[0]);
    assign mant_rnd = {1'b0, mant} + {24'd0, round_up};
    assign exp_fin  = mant_rnd[24] ? exp_norm + 10'sd1 : exp_norm;
    assign frac_fin = mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0];

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        div_d     = div_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        tag_d     = tag_q;
        o_d       = o_q;
        flags_d   = flags_q;
        out_tag_d = out_tag_q;
        unique case (state_q)
            S_IDLE: begin
                if (IN_VALID) begin
                    sign_d = sign_in;
                    exp_d  = exp_in;
                    div_d  = {1'b1, B[22:0]};
                    rem_d  = {2'b01, A[22:0]};
                    quo_d  = 27'd0;
                    cnt_d  = 5'd0;
                    tag_d  = IN_TAG;
                    if (special) begin
                        state_d   = S_DONE;
                        o_d       = spec_o;
                        flags_d   = spec_flags;
                        out_tag_d = IN_TAG;
                    end else begin
                        state_d = S_ITER;
                    end
                end
            end
            S_ITER: begin
                rem_d = rem_chain[STEPS_PER_CYCLE];
                quo_d = quo_chain[STEPS_PER_CYCLE];
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(N - 1)) state_d = S_ROUND;
            end
            S_ROUND: begin
                state_d   = S_DONE;
                out_tag_d = tag_q;
                if (exp_fin >= 10'sd255) begin
                    o_d     = {sign_q, 8'hFF, 23'd0};
                    flags_d = 5'b00101;
                end else if (exp_fin <= 10'sd0) begin
                    o_d     = {sign_q, 31'd0};
                    flags_d = 5'b00011;
                end else begin
                    o_d     = {sign_q, exp_fin[7:0], frac_fin};
                    flags_d = {4'b0000, guard | sticky};
                end
            end
            S_DONE: begin
                if (OUT_READY) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            sign_q      <= 1'b0;
            exp_q       <= 10'sd0;
            div_q       <= 24'd0;
            rem_q       <= 25'd0;
            quo_q       <= 27'd0;
            cnt_q       <= 5'd0;
            tag_q       <= '0;
            o_q         <= 32'd0;
            flags_q     <= 5'd0;
            out_tag_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            div_q       <= div_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            o_q         <= o_d;
            flags_q     <= flags_d;
            out_tag_q   <= out_tag_d;
            in_ready_q  <= (state_d == S_IDLE);
            out_valid_q <= (state_d == S_DONE);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign O         = o_q;
    assign FLAGS     = flags_q;
    assign OUT_TAG   = out_tag_q;
    assign BUSY      = busy_q;
endmodule

// File: tb/tb_fpu_f32_div_seq.sv
// Scoreboard bench for fpu_f32_div_seq: exact-integer reference divider,
// random and directed operands, backpressure, mid-iteration reset, S=3/9/27.
module tb_fpu_f32_div_seq;
    localparam int TAG_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] a_in, b_in, o;
    logic [4:0]  flags;
    logic [3:0]  in_tag, out_tag;

    logic        aux_valid;
    logic [31:0] aux_a, aux_b;
    logic [3:0]  aux_tag;
    logic        aux_in_ready [3];
    logic        aux_out_valid [3];
    logic        aux_busy [3];
    logic [31:0] aux_o [3];
    logic [4:0]  aux_flags [3];
    logic [3:0]  aux_out_tag [3];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit hold_out = 1'b0;
    bit rand_bp = 1'b0;

    typedef struct packed {
        logic [31:0] o;
        logic [4:0]  fl;
        logic        sp;
    } res_t;

    typedef struct {
        logic [31:0] o;
        logic [4:0]  fl;
        logic [3:0]  tag;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpu_f32_div_seq #(.STEPS_PER_CYCLE(1), .TAG_W(TAG_W)) u_dut (
        .MCLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .A(a_in), .B(b_in), .IN_TAG(in_tag), .OUT_VALID(out_valid),
        .OUT_READY(out_ready), .O(o), .FLAGS(flags), .OUT_TAG(out_tag), .BUSY(busy)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_aux
            localparam int S = (gi == 0) ? 3 : (gi == 1) ? 9 : 27;
            fpu_f32_div_seq #(.STEPS_PER_CYCLE(S), .TAG_W(TAG_W)) u_aux (
                .MCLK(clk), .RST(rst), .IN_VALID(aux_valid), .IN_READY(aux_in_ready[gi]),
                .A(aux_a), .B(aux_b), .IN_TAG(aux_tag), .OUT_VALID(aux_out_valid[gi]),
                .OUT_READY(1'b1), .O(aux_o[gi]), .FLAGS(aux_flags[gi]),
                .OUT_TAG(aux_out_tag[gi]), .BUSY(aux_busy[gi])
            );
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got no event, required one within the cycle bound (t=%0t)", name, $time);
    endtask

    // Exact reference: long division of the significands, RNE from the remainder.
    function automatic res_t ref_div(input logic [31:0] a, input logic [31:0] b);
        res_t   r;
        logic   s, az, bz, ai, bi, an, bn;
        int     ea, eb, e;
        longint ma, mb, n, m, rr;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        az = (ea == 0);
        bz = (eb == 0);
        ai = (ea == 255) && (a[22:0] == 23'd0);
        bi = (eb == 255) && (b[22:0] == 23'd0);
        an = (ea == 255) && (a[22:0] != 23'd0);
        bn = (eb == 255) && (b[22:0] != 23'd0);
        r.fl = 5'b00000;
        r.sp = 1'b1;
        r.o  = {s, 31'd0};
        if (an || bn) r.o = 32'h7FC00000;
        else if ((az && bz) || (ai && bi)) begin r.o = 32'h7FC00000; r.fl = 5'b10000; end
        else if (ai) r.o = {s, 8'hFF, 23'd0};
        else if (bz) begin r.o = {s, 8'hFF, 23'd0}; r.fl = 5'b01000; end
        else if (az || bi) r.o = {s, 31'd0};
        else begin
            r.sp = 1'b0;
            ma = longint'({1'b1, a[22:0]});
            mb = longint'({1'b1, b[22:0]});
            e  = ea - eb + 127;
            if (ma >= mb) n = ma << 23;
            else begin n = ma << 24; e = e - 1; end
            m  = n / mb;
            rr = n % mb;
            if ((2 * rr > mb) || ((2 * rr == mb) && m[0])) m = m + 1;
            if (m == longint'(1 << 24)) begin m = longint'(1 << 23); e = e + 1; end
            if (e >= 255) begin r.o = {s, 8'hFF, 23'd0}; r.fl = 5'b00101; end
            else if (e <= 0) begin r.o = {s, 31'd0}; r.fl = 5'b00011; end
            else begin r.o = {s, e[7:0], m[22:0]}; r.fl = {4'b0000, rr != 0}; end
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        int          k;
        logic [31:0] v;
        k = int'($urandom_range(9));
        if (k == 0) v = $urandom();
        else if (k == 1) begin
            case ($urandom_range(4))
                0: v = 32'h00000000;
                1: v = 32'h7F800000;
                2: v = 32'h7FC00001;
                3: v = 32'h00000123;
                default: v = 32'h3F800000;
            endcase
            v[31] = 1'($urandom_range(1));
        end else if (k == 2) v = {1'($urandom_range(1)), 8'($urandom_range(140, 115)), 23'h7FFFFF};
        else v = {1'($urandom_range(1)), 8'($urandom_range(154, 100)), 23'($urandom())};
        return v;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        res_t r;
        int   waited;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1; a_in = a; b_in = b; in_tag = t;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            fail_now("issue_in_ready");
            in_valid = 1'b0;
            return;
        end
        r = ref_div(a, b);
        sb.push_back('{o: r.o, fl: r.fl, tag: t, lat: (r.sp ? 1 : 29), acc: cyc});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int t;
        t = 0;
        while ((sb.size() != 0 || out_valid) && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0 || out_valid) fail_now("drain");
    endtask

    // Monitor: compares the queue head on every valid cycle, pops on handshake.
    bit prev_v = 1'b0;
    int vcyc = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
            end else begin
                if (out_valid) begin
                    if (!prev_v) vcyc = cyc;
                    if (sb.size() == 0) begin
                        fail_now("unexpected_output_empty_queue");
                    end else begin
                        e = sb[0];
                        if (!prev_v) chk("latency", 32'(vcyc - e.acc), 32'(e.lat));
                        chk("O", o, e.o);
                        chk("FLAGS", 32'(flags), 32'(e.fl));
                        chk("OUT_TAG", 32'(out_tag), 32'(e.tag));
                        chk("in_ready_in_done", 32'(in_ready), 32'd0);
                        if (out_ready) begin
                            $display("txn tag=%0d O=%h FLAGS=%b lat=%0d", out_tag, o, flags, vcyc - e.acc);
                            void'(sb.pop_front());
                        end
                    end
                end
                prev_v = out_valid;
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold_out) out_ready = 1'b0;
            else if (rand_bp) out_ready = ($urandom_range(3) != 0);
            else out_ready = 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation time %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    logic [31:0] aux_av [6];
    logic [31:0] aux_bv [6];
    int          aux_n [3];

    initial begin
        rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; in_tag = '0;
        aux_valid = 1'b0; aux_a = '0; aux_b = '0; aux_tag = '0;
        aux_n = '{3, 1, 0};
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_O", o, 32'd0);
        chk("rst_FLAGS", 32'(flags), 32'd0);
        chk("rst_OUT_TAG", 32'(out_tag), 32'd0);
        chk("rst_BUSY", 32'(busy), 32'd0);
        rst = 1'b0;

        // Directed operands.
        issue(32'h40C00000, 32'h40000000, 4'd5);
        issue(32'h3F800000, 32'h40400000, 4'd1);
        issue(32'h3F800000, 32'h00000000, 4'd2);
        issue(32'h00000000, 32'h80000000, 4'd3);
        issue(32'hFF800000, 32'h40000000, 4'd4);
        issue(32'h7F7FFFFF, 32'h3E800000, 4'd6);
        issue(32'h00800000, 32'h40800000, 4'd7);
        wait_drain(200);

        // Backpressure in DONE with a competing request that must be ignored.
        hold_out = 1'b1;
        issue(32'h3F800000, 32'h40400000, 4'd9);
        begin
            int t;
            t = 0;
            while (!out_valid && t < 60) begin @(negedge clk); t++; end
            if (!out_valid) fail_now("bp_wait_valid");
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; a_in = 32'h40000000; b_in = 32'h3F800000; in_tag = 4'hE;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        hold_out = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_out_valid", 32'(out_valid), 32'd0);
        repeat (40) @(negedge clk);
        chk("bp_no_ghost_busy", 32'(busy), 32'd0);

        // Random traffic with random consumer stalls.
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) issue(rand_op(), rand_op(), 4'($urandom_range(15)));
        rand_bp = 1'b0;
        wait_drain(400);

        // Asynchronous reset 7 cycles into ITER.
        issue(32'h40C00000, 32'h40000000, 4'd2);
        wait_drain(100);
        issue(32'h3F800000, 32'h40400000, 4'd8);
        repeat (7) @(posedge clk);
        #2;
        chk("iter_busy", 32'(busy), 32'd1);
        chk("iter_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        sb.delete();
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_O", o, 32'd0);
        chk("arst_FLAGS", 32'(flags), 32'd0);
        chk("arst_OUT_TAG", 32'(out_tag), 32'd0);
        chk("arst_BUSY", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(32'h40C00000, 32'h40000000, 4'd5);
        wait_drain(100);

        // Wider step counts: same results, shorter latency.
        aux_av = '{32'h3F800000, 32'h40C00000, 32'h3F800000, 32'h7F7FFFFF, 32'h00800000, 32'h0};
        aux_bv = '{32'h40400000, 32'h40000000, 32'h00000000, 32'h3E800000, 32'h40800000, 32'h0};
        for (int v = 0; v < 8; v++) begin
            res_t        r;
            int          acc;
            bit          seen [3];
            logic [31:0] av, bv;
            if (v < 5) begin av = aux_av[v]; bv = aux_bv[v]; end
            else begin
                av = {1'($urandom_range(1)), 8'($urandom_range(140, 115)), 23'($urandom())};
                bv = {1'($urandom_range(1)), 8'($urandom_range(140, 115)), 23'($urandom())};
            end
            r = ref_div(av, bv);
            @(negedge clk);
            aux_valid = 1'b1; aux_a = av; aux_b = bv; aux_tag = 4'(v);
            for (int g = 0; g < 3; g++) chk($sformatf("aux%0d_in_ready", g), 32'(aux_in_ready[g]), 32'd1);
            acc = cyc;
            @(negedge clk);
            aux_valid = 1'b0;
            for (int g = 0; g < 3; g++) seen[g] = 1'b0;
            for (int t = 0; t < 40; t++) begin
                for (int g = 0; g < 3; g++) begin
                    if (aux_out_valid[g] && !seen[g]) begin
                        seen[g] = 1'b1;
                        chk($sformatf("aux%0d_lat", g), 32'(cyc - acc), 32'(r.sp ? 1 : (27 / (g == 0 ? 3 : g == 1 ? 9 : 27)) + 2));
                        chk($sformatf("aux%0d_O", g), aux_o[g], r.o);
                        chk($sformatf("aux%0d_FLAGS", g), 32'(aux_flags[g]), 32'(r.fl));
                        chk($sformatf("aux%0d_OUT_TAG", g), 32'(aux_out_tag[g]), 32'(v));
                        chk($sformatf("aux%0d_busy", g), 32'(aux_busy[g]), 32'd1);
                        $display("txn aux%0d S-index=%0d tag=%0d O=%h FLAGS=%b lat=%0d",
                                 g, aux_n[g], aux_out_tag[g], aux_o[g], aux_flags[g], cyc - acc);
                    end
                end
                if (seen[0] && seen[1] && seen[2]) break;
                @(negedge clk);
            end
            for (int g = 0; g < 3; g++) if (!seen[g]) fail_now($sformatf("aux%0d_timeout", g));
            repeat (2) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
